// File: rtl/nanov_serial_alu.sv
// Bit-serial ALU (ADD/SUB/XOR/OR/AND) with branch-compare flags taken from a SUB pass.
// Optional parallel result capture port enabled by defining NANOV_ALU_RESULT_REG_EN.
module nanov_serial_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            pause,
    input  logic            a_bit,
    input  logic            b_bit,
    output logic            rd_bit,
    output logic            rd_valid,
    output logic            busy,
    output logic            done,
    output logic            cmp_eq,
    output logic            cmp_lt,
    output logic            cmp_ltu
`ifdef NANOV_ALU_RESULT_REG_EN
    ,
    output logic [XLEN-1:0] result_par
`endif
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_XOR = 3'b100,
        OP_OR  = 3'b110,
        OP_AND = 3'b111
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [2:0]      op_q;
    logic            neq;

    logic            b_eff;
    logic            sum_bit;
    logic            carry_next;
    logic            last_bit;

    assign busy     = (state == S_RUN);
    assign rd_valid = busy & ~pause;
    assign last_bit = (cnt == CW'(XLEN - 1));

    // SUB is A + ~B + 1: the +1 comes from carry being preset at start.
    always_comb begin
        b_eff      = (op_q == OP_SUB) ? ~b_bit : b_bit;
        sum_bit    = a_bit ^ b_eff ^ carry;
        carry_next = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
        case (op_q)
            OP_ADD, OP_SUB: rd_bit = sum_bit;
            OP_XOR:         rd_bit = a_bit ^ b_bit;
            OP_OR:          rd_bit = a_bit | b_bit;
            OP_AND:         rd_bit = a_bit & b_bit;
            default:        rd_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            op_q    <= OP_ADD;
            neq     <= 1'b0;
            done    <= 1'b0;
            cmp_eq  <= 1'b0;
            cmp_lt  <= 1'b0;
            cmp_ltu <= 1'b0;
`ifdef NANOV_ALU_RESULT_REG_EN
            result_par <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    state <= S_RUN;
                    op_q  <= op;
                    cnt   <= '0;
                    carry <= (op == OP_SUB);
                    neq   <= 1'b0;
`ifdef NANOV_ALU_RESULT_REG_EN
                    result_par <= '0;
`endif
                end
            end else if (!pause) begin
                cnt   <= cnt + CW'(1);
                carry <= carry_next;
                neq   <= neq | (a_bit ^ b_bit);
`ifdef NANOV_ALU_RESULT_REG_EN
                result_par[cnt] <= rd_bit;
`endif
                if (last_bit) begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    done  <= 1'b1;
                    // Signed LT: differing MSBs decide directly, otherwise the sign of A-B does.
                    if (op_q == OP_SUB) begin
                        cmp_eq  <= ~(neq | (a_bit ^ b_bit));
                        cmp_ltu <= ~carry_next;
                        cmp_lt  <= (a_bit != b_bit) ? a_bit : sum_bit;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nanov_serial_alu.sv
// Self-checking bench for nanov_serial_alu: word-level reference model plus directed passes.
// Define NANOV_ALU_RESULT_REG_EN on both files to also check result_par.
module tb_nanov_serial_alu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic        pause;
    logic        a_bit;
    logic        b_bit;
    logic        rd_bit;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        cmp_eq;
    logic        cmp_lt;
    logic        cmp_ltu;
`ifdef NANOV_ALU_RESULT_REG_EN
    logic [31:0] result_par;
`endif

    always #5 clk = ~clk;

    nanov_serial_alu #(.XLEN(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .op       (op),
        .pause    (pause),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .rd_bit   (rd_bit),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .cmp_eq   (cmp_eq),
        .cmp_lt   (cmp_lt),
        .cmp_ltu  (cmp_ltu)
`ifdef NANOV_ALU_RESULT_REG_EN
        ,
        .result_par (result_par)
`endif
    );

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] OR  = 3'b110;
    localparam logic [2:0] AND = 3'b111;
    localparam int NONE = -1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] golden(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            ADD:     return a + b;
            SUB:     return a - b;
            XOR:     return a ^ b;
            OR:      return a | b;
            AND:     return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // Word-level reference: operands of the accepted pass, full result, consumed-bit index.
    logic [31:0] cur_a, cur_b;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_op;
    logic        m_busy, m_done, m_eq, m_lt, m_ltu;
    int          m_idx;
    logic [31:0] cap;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_idx <= 0; m_op <= ADD;
            m_eq <= 1'b0; m_lt <= 1'b0; m_ltu <= 1'b0;
            m_a <= '0; m_b <= '0; m_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1; m_idx <= 0; m_op <= op;
                    m_a <= cur_a; m_b <= cur_b; m_res <= golden(op, cur_a, cur_b);
                end
            end else if (!pause) begin
                m_idx <= m_idx + 1;
                if (m_idx == 31) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_idx  <= 0;
                    if (m_op == SUB) begin
                        m_eq  <= (m_a == m_b);
                        m_lt  <= ($signed(m_a) < $signed(m_b));
                        m_ltu <= (m_a < m_b);
                    end
                end
            end
        end
    end

    initial begin
        cap = '0;
        forever begin
            @(negedge clk);
            #2;
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_busy & ~pause});
            chk("cmp_eq", {31'b0, cmp_eq}, {31'b0, m_eq});
            chk("cmp_lt", {31'b0, cmp_lt}, {31'b0, m_lt});
            chk("cmp_ltu", {31'b0, cmp_ltu}, {31'b0, m_ltu});
            if (m_busy && !pause) begin
                chk("rd_bit", {31'b0, rd_bit}, {31'b0, m_res[m_idx[4:0]]});
                cap[m_idx[4:0]] = rd_bit;
            end
`ifdef NANOV_ALU_RESULT_REG_EN
            if (m_done) chk("result_par", result_par, m_res);
`endif
        end
    end

    // Drives the start cycle and 32 bit cycles; pauses are inserted before the bit they stall.
    task automatic run_pass(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int pb0, input int pl0, input int pb1, input int pl1,
                            input int start_at, input int rst_at);
        int np;
        @(negedge clk);
        start = 1'b1; op = o; cur_a = a; cur_b = b; pause = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        for (int i = 0; i < 32; i++) begin
            np = (i == pb0) ? pl0 : ((i == pb1) ? pl1 : 0);
            for (int k = 0; k < np; k++) begin
                @(negedge clk);
                start = 1'b0; pause = 1'b1; a_bit = a[i]; b_bit = b[i];
            end
            @(negedge clk);
            pause = 1'b0; a_bit = a[i]; b_bit = b[i];
            start = (i == start_at);
            op    = (i == start_at) ? ~o : o;
            if (i == rst_at) begin
                #3;
                rstn = 1'b0;
                #1;
                chk("rst_busy", {31'b0, busy}, 32'h0);
                chk("rst_done", {31'b0, done}, 32'h0);
                chk("rst_flags", {29'b0, cmp_eq, cmp_lt, cmp_ltu}, 32'h0);
                @(negedge clk);
                rstn = 1'b1; start = 1'b0; pause = 1'b0;
                return;
            end
        end
    endtask

    task automatic finish_pass(input string name);
        @(negedge clk);
        start = 1'b0; pause = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        #3;
        chk(name, {31'b0, done}, 32'h1);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; pause = 1'b0; op = ADD;
        a_bit = 1'b0; b_bit = 1'b0; cur_a = '0; cur_b = '0;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_state", {28'b0, busy, done, cmp_eq, cmp_lt}, 32'h0);
        chk("reset_ltu", {31'b0, cmp_ltu}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        run_pass(ADD, 32'h0000_0005, 32'h0000_0003, NONE, 0, NONE, 0, NONE, NONE);
        finish_pass("add_done_at_33");
        chk("add_stream", cap, 32'h0000_0008);
`ifdef NANOV_ALU_RESULT_REG_EN
        chk("add_result_par", result_par, 32'h0000_0008);
`endif

        run_pass(SUB, 32'h0000_0003, 32'h0000_0005, NONE, 0, NONE, 0, NONE, NONE);
        finish_pass("sub1_done");
        chk("sub1_stream", cap, 32'hFFFF_FFFE);
        chk("sub1_flags", {29'b0, cmp_eq, cmp_lt, cmp_ltu}, 32'h3);

        run_pass(SUB, 32'h8000_0000, 32'h0000_0001, NONE, 0, NONE, 0, NONE, NONE);
        finish_pass("sub2_done");
        chk("sub2_flags", {29'b0, cmp_eq, cmp_lt, cmp_ltu}, 32'h2);

        run_pass(SUB, 32'h1234_5678, 32'h1234_5678, NONE, 0, NONE, 0, NONE, NONE);
        finish_pass("sub_eq_done");
        chk("sub_eq_stream", cap, 32'h0);
        chk("sub_eq_flags", {29'b0, cmp_eq, cmp_lt, cmp_ltu}, 32'h4);

        run_pass(AND, 32'hFFFF_0000, 32'h0F0F_0F0F, NONE, 0, NONE, 0, NONE, NONE);
        finish_pass("and_done");
        chk("and_stream", cap, 32'h0F0F_0000);
        chk("and_keeps_flags", {29'b0, cmp_eq, cmp_lt, cmp_ltu}, 32'h4);

        run_pass(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 7, 3, 31, 1, NONE, NONE);
        finish_pass("paused_done_at_37");
        chk("paused_stream", cap, 32'h0);

        run_pass(SUB, 32'h0000_0005, 32'h0000_0009, NONE, 0, NONE, 0, NONE, 12);

        run_pass(XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, NONE, 0, NONE, 0, NONE, NONE);
        finish_pass("xor_done");
        chk("xor_stream", cap, 32'h0F0F_F0F0);
        chk("xor_flags_cleared", {29'b0, cmp_eq, cmp_lt, cmp_ltu}, 32'h0);

        // Stray start at bit 5 (with a different op) must be ignored; the next pass starts in the done cycle.
        run_pass(OR, 32'h0000_00F0, 32'h0000_0F00, NONE, 0, NONE, 0, 5, NONE);
        run_pass(ADD, 32'h0000_0001, 32'h0000_0002, NONE, 0, NONE, 0, NONE, NONE);
        finish_pass("chained_done");
        chk("chained_stream", cap, 32'h0000_0003);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
